// File: rtl/regfile_csr_unit_pkg.sv
// Shared constants for the diag-v2 register file / CSR unit: CSR addresses,
// csr_op encodings, zero constants and small decode helpers.
package regfile_csr_unit_pkg;

  // Machine-mode counter CSRs (read/write)
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;

  // Machine-mode control CSRs
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;

  // User-mode read-only shadows of the counters
  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_INSTRET       = 12'hC02;
  localparam logic [11:0] CSR_HPMCOUNTER3   = 12'hC03;

  // csr_op encodings
  localparam logic [1:0] CSR_OP_NONE = 2'b00;
  localparam logic [1:0] CSR_OP_RW   = 2'b01;
  localparam logic [1:0] CSR_OP_RS   = 2'b10;
  localparam logic [1:0] CSR_OP_RC   = 2'b11;

  localparam logic [4:0] RegZero = 5'd0;

  // Widest supported data path; narrower users take the low bits.
  localparam int unsigned MaxXlen = 64;
  localparam logic [MaxXlen-1:0] DataZero = {MaxXlen{1'b0}};

  // True when the op actually writes the CSR. RS/RC with a zero operand
  // degrade to a pure read, which is what makes them legal on shadows.
  function automatic logic csr_op_writes(input logic [1:0] op, input logic wdata_nz);
    logic w;
    case (op)
      CSR_OP_RW: w = 1'b1;
      CSR_OP_RS: w = wdata_nz;
      CSR_OP_RC: w = wdata_nz;
      default:   w = 1'b0;
    endcase
    return w;
  endfunction

  // Address offset of counter-bank slot idx from the mcycle/cycle base.
  // Slot 0 is mcycle, slot 1 minstret (offset 2, skipping time), slot 2+k
  // is mhpmcounter(3+k).
  function automatic logic [11:0] cnt_csr_offset(input int unsigned idx);
    return (idx == 0) ? 12'd0 : 12'(idx + 1);
  endfunction

endpackage

// File: rtl/regfile_csr_unit_csr_counter_bank.sv
// Bank of free-running counters (mcycle, minstret, mhpmcounters). Each slot
// increments on its event unless inhibited; a CSR write replaces the
// increment for that cycle and is stored exactly.
module regfile_csr_unit_csr_counter_bank
  import regfile_csr_unit_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int NUM_CNT = 6
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CNT-1:0]             i_inc,
  input  logic [NUM_CNT-1:0]             i_inhibit,
  input  logic [NUM_CNT-1:0]             i_we,
  input  logic [XLEN-1:0]                i_wdata,
  output logic [NUM_CNT-1:0][XLEN-1:0]   o_cnt
);

  localparam logic [XLEN-1:0] Zero = XLEN'(DataZero);
  localparam logic [XLEN-1:0] One  = {{(XLEN-1){1'b0}}, 1'b1};

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    logic [XLEN-1:0] r_cnt;

    // Counter slot: write overrides increment; wraps modulo 2^XLEN.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_cnt <= Zero;
      end else if (i_we[g]) begin
        r_cnt <= i_wdata;
      end else if (i_inc[g] && !i_inhibit[g]) begin
        r_cnt <= r_cnt + One;
      end
    end

    assign o_cnt[g] = r_cnt;
  end

endmodule

// File: rtl/regfile_csr_unit.sv
// Integer register file (2R/1W with write bypass) plus machine-mode CSR unit
// with mcycle/minstret/mhpmcounter bank, mcountinhibit and mscratch.
module regfile_csr_unit
  import regfile_csr_unit_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int NUM_HPM = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         rs1_addr,
  input  logic [4:0]         rs2_addr,
  output logic [XLEN-1:0]    rs1_data,
  output logic [XLEN-1:0]    rs2_data,
  input  logic               rd_we,
  input  logic [4:0]         rd_addr,
  input  logic [XLEN-1:0]    rd_data,
  input  logic [1:0]         csr_op,
  input  logic [11:0]        csr_addr,
  input  logic [XLEN-1:0]    csr_wdata,
  output logic [XLEN-1:0]    csr_rdata,
  output logic               csr_illegal,
  input  logic               retire,
  input  logic [NUM_HPM-1:0] hpm_event
);

  localparam int NUM_CNT = NUM_HPM + 2;
  localparam logic [XLEN-1:0] Zero = XLEN'(DataZero);

  logic [XLEN-1:0]               r_gpr [32];
  logic [NUM_CNT-1:0]            r_inhibit;   // compacted: CY, IR, HPM0..
  logic [XLEN-1:0]               r_mscratch;

  logic [NUM_CNT-1:0][XLEN-1:0]  w_cnt;
  logic [NUM_CNT-1:0]            w_cnt_inc;
  logic [NUM_CNT-1:0]            w_cnt_we;
  logic [NUM_CNT-1:0]            w_hit_m;
  logic [NUM_CNT-1:0]            w_hit_u;
  logic [XLEN-1:0]               w_cnt_rd;
  logic                          w_hit_inh;
  logic                          w_hit_scr;
  logic                          w_impl;
  logic                          w_ro;
  logic [XLEN-1:0]               w_inh_view;
  logic [NUM_CNT-1:0]            w_inh_next;
  logic [XLEN-1:0]               w_old;
  logic [XLEN-1:0]               w_new;
  logic                          w_wr_op;
  logic                          w_do_write;

  // ---------------------------------------------------------------- GPRs

  // GPR write port; x0 is never written so it stays zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_gpr[i] <= Zero;
    end else if (rd_we && (rd_addr != RegZero)) begin
      r_gpr[rd_addr] <= rd_data;
    end
  end

  // Read port 1 with same-cycle bypass; bypass is suppressed during reset.
  always_comb begin
    if (reset || (rs1_addr == RegZero)) begin
      rs1_data = Zero;
    end else if (rd_we && (rd_addr == rs1_addr)) begin
      rs1_data = rd_data;
    end else begin
      rs1_data = r_gpr[rs1_addr];
    end
  end

  // Read port 2 with same-cycle bypass; bypass is suppressed during reset.
  always_comb begin
    if (reset || (rs2_addr == RegZero)) begin
      rs2_data = Zero;
    end else if (rd_we && (rd_addr == rs2_addr)) begin
      rs2_data = rd_data;
    end else begin
      rs2_data = r_gpr[rs2_addr];
    end
  end

  // ---------------------------------------------------------------- decode

  // Match csr_addr against machine counters and their read-only shadows.
  always_comb begin
    w_hit_m  = {NUM_CNT{1'b0}};
    w_hit_u  = {NUM_CNT{1'b0}};
    w_cnt_rd = Zero;
    for (int j = 0; j < NUM_CNT; j++) begin
      w_hit_m[j] = (csr_addr == (CSR_MCYCLE + cnt_csr_offset(j)));
      w_hit_u[j] = (csr_addr == (CSR_CYCLE  + cnt_csr_offset(j)));
      w_cnt_rd   = w_cnt_rd | (w_cnt[j] & {XLEN{w_hit_m[j] | w_hit_u[j]}});
    end
  end

  assign w_hit_inh = (csr_addr == CSR_MCOUNTINHIBIT);
  assign w_hit_scr = (csr_addr == CSR_MSCRATCH);
  assign w_impl    = (|w_hit_m) | (|w_hit_u) | w_hit_inh | w_hit_scr;
  assign w_ro      = |w_hit_u;

  // Architectural view of mcountinhibit: CY at bit 0, IR at 2, HPMk at 3+k.
  always_comb begin
    w_inh_view    = Zero;
    w_inh_view[0] = r_inhibit[0];
    w_inh_view[2] = r_inhibit[1];
    for (int k = 0; k < NUM_HPM; k++) w_inh_view[3+k] = r_inhibit[2+k];
  end

  // Old CSR value; unimplemented addresses read as zero.
  always_comb begin
    if (w_hit_inh) begin
      w_old = w_inh_view;
    end else if (w_hit_scr) begin
      w_old = r_mscratch;
    end else begin
      w_old = w_cnt_rd;
    end
  end

  // ---------------------------------------------------------------- RMW

  // New CSR value from the read-modify-write op.
  always_comb begin
    case (csr_op)
      CSR_OP_RW: w_new = csr_wdata;
      CSR_OP_RS: w_new = w_old | csr_wdata;
      CSR_OP_RC: w_new = w_old & ~csr_wdata;
      default:   w_new = w_old;
    endcase
  end

  // Compact a written mcountinhibit value back to the implemented bits.
  always_comb begin
    w_inh_next    = {NUM_CNT{1'b0}};
    w_inh_next[0] = w_new[0];
    w_inh_next[1] = w_new[2];
    for (int k = 0; k < NUM_HPM; k++) w_inh_next[2+k] = w_new[3+k];
  end

  assign w_wr_op     = csr_op_writes(csr_op, |csr_wdata);
  assign csr_illegal = (csr_op != CSR_OP_NONE) && (!w_impl || (w_ro && w_wr_op));
  assign w_do_write  = w_wr_op && !csr_illegal;
  assign csr_rdata   = w_old;

  // ---------------------------------------------------------------- state

  // mcountinhibit and mscratch update on the edge after a legal write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inhibit  <= {NUM_CNT{1'b0}};
      r_mscratch <= Zero;
    end else begin
      if (w_do_write && w_hit_inh) r_inhibit  <= w_inh_next;
      if (w_do_write && w_hit_scr) r_mscratch <= w_new;
    end
  end

  assign w_cnt_inc = {hpm_event, retire, 1'b1};
  assign w_cnt_we  = w_hit_m & {NUM_CNT{w_do_write}};

  regfile_csr_unit_csr_counter_bank #(
    .XLEN    (XLEN),
    .NUM_CNT (NUM_CNT)
  ) u_counter_bank (
    .clk       (clk),
    .reset     (reset),
    .i_inc     (w_cnt_inc),
    .i_inhibit (r_inhibit),
    .i_we      (w_cnt_we),
    .i_wdata   (w_new),
    .o_cnt     (w_cnt)
  );

endmodule

// File: tb/tb_regfile_csr_unit.sv
// Directed + randomized bench for regfile_csr_unit against a behavioural model.
module tb_regfile_csr_unit;

  localparam int XLEN    = 64;
  localparam int NUM_HPM = 4;
  localparam logic [63:0] INH_MASK = 64'h5 | (((64'd1 << NUM_HPM) - 64'd1) << 3);

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [4:0]         rs1_addr = 5'd0;
  logic [4:0]         rs2_addr = 5'd0;
  logic [XLEN-1:0]    rs1_data;
  logic [XLEN-1:0]    rs2_data;
  logic               rd_we = 1'b0;
  logic [4:0]         rd_addr = 5'd0;
  logic [XLEN-1:0]    rd_data = 64'd0;
  logic [1:0]         csr_op = 2'b00;
  logic [11:0]        csr_addr = 12'h000;
  logic [XLEN-1:0]    csr_wdata = 64'd0;
  logic [XLEN-1:0]    csr_rdata;
  logic               csr_illegal;
  logic               retire = 1'b0;
  logic [NUM_HPM-1:0] hpm_event = '0;

  always #5 clk = ~clk;

  regfile_csr_unit #(.XLEN(XLEN), .NUM_HPM(NUM_HPM)) dut (
    .clk(clk), .reset(reset),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
    .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .retire(retire), .hpm_event(hpm_event)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [63:0] m_gpr [32];
  logic [63:0] m_hpm [NUM_HPM];
  logic [63:0] m_mcycle, m_minstret, m_scratch, m_inh;

  function automatic void m_clear();
    for (int i = 0; i < 32; i++) m_gpr[i] = 64'd0;
    for (int k = 0; k < NUM_HPM; k++) m_hpm[k] = 64'd0;
    m_mcycle = 64'd0; m_minstret = 64'd0; m_scratch = 64'd0; m_inh = 64'd0;
  endfunction

  function automatic void m_lookup(input logic [11:0] a, output logic [63:0] v,
                                   output bit impl, output bit ro);
    int off;
    impl = 1'b1; ro = 1'b0; v = 64'd0;
    off = (a >= 12'hC00) ? int'(a) - 'hC00 : int'(a) - 'hB00;
    if (a >= 12'hC00) ro = 1'b1;
    if (a == 12'h320) begin ro = 1'b0; v = m_inh; end
    else if (a == 12'h340) begin ro = 1'b0; v = m_scratch; end
    else if ((a >= 12'hB00 && a < 12'hB20) || (a >= 12'hC00 && a < 12'hC20)) begin
      if (off == 0) v = m_mcycle;
      else if (off == 2) v = m_minstret;
      else if (off >= 3 && off < 3 + NUM_HPM) v = m_hpm[off-3];
      else begin impl = 1'b0; ro = 1'b0; end
    end else begin
      impl = 1'b0; ro = 1'b0;
    end
  endfunction

  function automatic void m_write(input logic [11:0] a, input logic [63:0] nv);
    if (a == 12'hB00) m_mcycle = nv;
    else if (a == 12'hB02) m_minstret = nv;
    else if (a >= 12'hB03 && int'(a) < 'hB03 + NUM_HPM) m_hpm[int'(a) - 'hB03] = nv;
    else if (a == 12'h320) m_inh = nv & INH_MASK;
    else if (a == 12'h340) m_scratch = nv;
  endfunction

  function automatic logic [63:0] m_rs(input logic [4:0] a);
    if (reset || a == 5'd0) return 64'd0;
    if (rd_we && rd_addr == a) return rd_data;
    return m_gpr[a];
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle: compare outputs against the model, then advance the model.
  task automatic step();
    logic [63:0] v, nv;
    bit impl, ro, wr, ill;
    if (reset) m_clear();
    #1;
    m_lookup(csr_addr, v, impl, ro);
    wr  = (csr_op == 2'b01) || ((csr_op != 2'b00) && (csr_wdata != 64'd0));
    ill = (csr_op != 2'b00) && (!impl || (ro && wr));
    check("rs1", rs1_data, m_rs(rs1_addr));
    check("rs2", rs2_data, m_rs(rs2_addr));
    check("rdata", csr_rdata, v);
    check("illegal", {63'd0, csr_illegal}, {63'd0, ill});
    @(posedge clk);
    if (reset) begin
      m_clear();
    end else begin
      if (!m_inh[0]) m_mcycle = m_mcycle + 64'd1;
      if (!m_inh[2]) m_minstret = m_minstret + {63'd0, retire};
      for (int k = 0; k < NUM_HPM; k++)
        if (!m_inh[3+k]) m_hpm[k] = m_hpm[k] + {63'd0, hpm_event[k]};
      if (wr && !ill) begin
        case (csr_op)
          2'b01:   nv = csr_wdata;
          2'b10:   nv = v | csr_wdata;
          default: nv = v & ~csr_wdata;
        endcase
        m_write(csr_addr, nv);
      end
      if (rd_we && rd_addr != 5'd0) m_gpr[rd_addr] = rd_data;
    end
    @(negedge clk);
  endtask

  task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [63:0] wd);
    csr_op = op; csr_addr = a; csr_wdata = wd;
  endtask

  logic [11:0] addr_tab [16] = '{12'hB00, 12'hB02, 12'hB03, 12'hB04, 12'hB05, 12'hB06,
                                 12'hB07, 12'hB01, 12'h320, 12'h340, 12'hC00, 12'hC02,
                                 12'hC03, 12'hC06, 12'hC07, 12'h123};

  initial begin
    m_clear();
    #1 reset = 1'b1;
    @(negedge clk);
    // In reset: everything reads zero, bypass suppressed
    rd_we = 1'b1; rd_addr = 5'd5; rd_data = 64'hDEAD; rs1_addr = 5'd5;
    csr(2'b10, 12'hB00, 64'd0);
    #1;
    check("rst_rs1", rs1_data, 64'd0);
    check("rst_rdata", csr_rdata, 64'd0);
    check("rst_illegal", {63'd0, csr_illegal}, 64'd0);
    step();
    reset = 1'b0;

    // Bypass and x0
    csr(2'b00, 12'h000, 64'd0);
    rd_we = 1'b1; rd_addr = 5'd5; rd_data = 64'hDEAD; rs1_addr = 5'd5; rs2_addr = 5'd0;
    #1 check("bypass_x5", rs1_data, 64'hDEAD);
    step();
    rd_addr = 5'd0; rd_data = 64'd7; rs1_addr = 5'd0; rs2_addr = 5'd5;
    #1 check("x0_write", rs1_data, 64'd0);
    check("x5_stored", rs2_data, 64'hDEAD);
    step();
    rd_we = 1'b0;
    repeat (8) step();

    // mcycle after 10 cycles; shadow one cycle later
    csr(2'b10, 12'hB00, 64'd0);
    #1 check("mcycle_10", csr_rdata, 64'd10);
    check("mcycle_legal", {63'd0, csr_illegal}, 64'd0);
    step();
    csr(2'b10, 12'hC00, 64'd0);
    #1 check("cycle_11", csr_rdata, 64'd11);
    step();

    // Inhibit CY|IR, then release
    retire = 1'b1;
    csr(2'b01, 12'h320, 64'h5);   #1 check("inh_old", csr_rdata, 64'd0);  step();
    csr(2'b10, 12'hB00, 64'd0);   #1 check("frozen_cy", csr_rdata, 64'd13); step();
    csr(2'b10, 12'hB02, 64'd0);   #1 check("frozen_ir", csr_rdata, 64'd1);  step();
    csr(2'b10, 12'hB00, 64'd0);   #1 check("frozen_cy2", csr_rdata, 64'd13); step();
    csr(2'b01, 12'h320, 64'd0);   #1 check("inh_read", csr_rdata, 64'd5);  step();
    csr(2'b10, 12'hB00, 64'd0);   #1 check("inh_lag", csr_rdata, 64'd13);  step();
    csr(2'b10, 12'hB02, 64'd0);   #1 check("resume_ir", csr_rdata, 64'd2); step();

    // Write override and wrap of minstret
    csr(2'b01, 12'hB02, 64'hFFFF_FFFF_FFFF_FFFF);
    #1 check("pre_write_ir", csr_rdata, 64'd3);
    step();
    csr(2'b10, 12'hB02, 64'd0);
    #1 check("ir_ones", csr_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    retire = 1'b0;
    #1 check("ir_wrap", csr_rdata, 64'd0);
    step();

    // HPM events on counters 4 and 6
    csr(2'b00, 12'h000, 64'd0);
    hpm_event = 4'b1010;
    repeat (3) step();
    hpm_event = 4'b0000;
    csr(2'b10, 12'hB03, 64'd0); #1 check("hpm3", csr_rdata, 64'd0); step();
    csr(2'b10, 12'hB04, 64'd0); #1 check("hpm4", csr_rdata, 64'd3); step();
    csr(2'b10, 12'hB05, 64'd0); #1 check("hpm5", csr_rdata, 64'd0); step();
    csr(2'b10, 12'hB06, 64'd0); #1 check("hpm6", csr_rdata, 64'd3); step();
    csr(2'b10, 12'hB07, 64'd0);
    #1 check("unimpl_ill", {63'd0, csr_illegal}, 64'd1);
    check("unimpl_rdata", csr_rdata, 64'd0);
    step();

    // Write to read-only shadow is illegal
    csr(2'b01, 12'hC00, 64'd1);
    #1 check("ro_write_ill", {63'd0, csr_illegal}, 64'd1);
    step();
    csr(2'b10, 12'hC00, 64'd0);
    #1 check("ro_read_ok", {63'd0, csr_illegal}, 64'd0);
    step();

    // mscratch RC
    csr(2'b01, 12'h340, 64'hFF);  step();
    csr(2'b11, 12'h340, 64'h0F);  #1 check("rc_old", csr_rdata, 64'hFF); step();
    csr(2'b10, 12'h340, 64'd0);   #1 check("rc_new", csr_rdata, 64'hF0); step();

    // Asynchronous reset mid-cycle clears state without an edge
    csr(2'b00, 12'h340, 64'd0); rs1_addr = 5'd5;
    #3 reset = 1'b1;
    #1 check("async_scratch", csr_rdata, 64'd0);
    check("async_gpr", rs1_data, 64'd0);
    m_clear();
    @(negedge clk);
    step();
    reset = 1'b0;

    // Randomized phase
    for (int i = 0; i < 400; i++) begin
      reset     = (i == 250);
      rs1_addr  = 5'($urandom);
      rs2_addr  = 5'($urandom);
      rd_we     = 1'($urandom);
      rd_addr   = ($urandom_range(0, 3) == 0) ? rs1_addr : 5'($urandom);
      rd_data   = {$urandom, $urandom};
      csr_op    = 2'($urandom);
      csr_addr  = addr_tab[$urandom_range(0, 15)];
      csr_wdata = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
      if (csr_addr == 12'h320 && $urandom_range(0, 1) == 0) csr_wdata = 64'd0;
      retire    = 1'($urandom);
      hpm_event = 4'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_csr_unit.md
# regfile_csr_unit

Parametrised integer register file plus machine-mode CSR/counter unit for the pipelined diag-v2 core. It provides two GPR read ports with same-cycle write bypass and one GPR write port. It executes CSRRW/CSRRS/CSRRC read-modify-write operations and maintains mcycle, minstret and a configurable bank of hardware performance counters gated by mcountinhibit. It sits between decode (reads) and writeback (writes, retire and event strobes).

## Interface
Parameters:
- XLEN, 64, data and counter width
- NUM_HPM, 4, number of mhpmcounterN implemented (N = 3 .. 3+NUM_HPM-1), legal range 1..29

Ports:
- clk  in  1  core clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- rs1_addr, rs2_addr  in  5  GPR read addresses
- rs1_data, rs2_data  out  XLEN  GPR read data, combinational
- rd_we  in  1  GPR write enable
- rd_addr  in  5  GPR write address
- rd_data  in  XLEN  GPR write data
- csr_op  in  2  00 none, 01 RW, 10 RS (set), 11 RC (clear)
- csr_addr  in  12  CSR address
- csr_wdata  in  XLEN  CSR operand (rs1 value or zero-extended uimm, resolved upstream)
- csr_rdata  out  XLEN  old CSR value, combinational
- csr_illegal  out  1  combinational; high when csr_op != 00 and the access is illegal
- retire  in  1  one valid instruction retires this cycle
- hpm_event  in  NUM_HPM  bit k increments mhpmcounter(3+k)

## Operation
- GPR x0 reads 0 always; writes to x0 are discarded.
- Bypass: if rd_we and rd_addr == rsN_addr != 0, rsN_data = rd_data, otherwise the stored value.
- Implemented CSRs:
  - mcycle 0xB00, minstret 0xB02, mhpmcounter3+k at 0xB03+k: read/write.
  - mcountinhibit 0x320: read/write; bit0 CY, bit2 IR, bit 3+k HPMk, all other bits read 0.
  - mscratch 0x340: read/write.
  - cycle 0xC00, instret 0xC02, hpmcounter3+k at 0xC03+k: read-only shadows.
- New value: RW → wdata; RS → old | wdata; RC → old & ~wdata.
- RS/RC with csr_wdata == 0 perform no write and cannot be illegal on a read-only address.
- Illegal access: an unimplemented address (csr_rdata = 0), or a write-performing op to a read-only shadow. An illegal access changes no state.
- Counter increments each cycle, applied unless inhibited:
  - mcycle += 1 (CY)
  - minstret += retire (IR)
  - mhpmcounter(3+k) += hpm_event[k] (HPMk)
- Counters wrap modulo 2^XLEN.
- Priority: a legal CSR write to a counter in the same cycle replaces that counter's increment. The written value is stored exactly, with no +1.
- A write to mcountinhibit takes effect from the next cycle; the current cycle's increments use the old inhibit value.

## Timing
- Reset (async assert, released synchronously by clk domain upstream): all GPRs, counters, mscratch and mcountinhibit are 0.
- During reset, rs*_data, csr_rdata and csr_illegal follow the cleared state combinationally: rs*_data = 0, csr_rdata = 0, csr_illegal = 0 when csr_op = 00.
- GPR write and CSR write become visible at the rising edge; read-after-write latency is 0 via bypass for GPRs and 1 cycle for CSRs.
- csr_rdata returns the pre-edge value, excluding that cycle's increment: a read of mcycle at cycle t returns t cycles after reset release.
- Reset asserted mid-operation clears state immediately, without waiting for an edge; an in-flight CSR write is lost.

## Structure
- The shared constants header carries the CSR addresses (MCYCLE, MINSTRET, MHPMCOUNTER3 base, MCOUNTINHIBIT, MSCRATCH, user shadow bases), the csr_op encodings, RegZero and DataZero.
- Sub-module csr_counter_bank holds mcycle, minstret and NUM_HPM counters with per-counter increment, inhibit and write-override. It is instantiated once.
- The top level holds the GPR array, bypass, address decode, RMW and illegal logic.

## Test plan
- Reset, then write x5 = 0xDEAD with rs1_addr = 5 in the same cycle → rs1_data = 0xDEAD the same cycle. Write x0 = 7 → x0 reads 0.
- Release reset, idle 10 cycles, CSRRS rd mcycle with wdata 0 → csr_rdata = 10, no illegal. Then read cycle 0xC00 → 11.
- CSRRW mcountinhibit = 0x5 at cycle t → mcycle and minstret frozen from t+1 while retire = 1. Clear to 0 → counting resumes.
- CSRRW minstret = 0xFFFF_FFFF_FFFF_FFFF with retire = 1 in the same cycle → next cycle minstret = all-ones. Next retire → 0 (wrap).
- NUM_HPM = 4, hpm_event = 4'b1010 for 3 cycles → mhpmcounter4 = 3, mhpmcounter6 = 3, mhpmcounter3 = 0, mhpmcounter5 = 0. Read 0xB07 → illegal, rdata 0.
- CSRRW to 0xC00 with wdata 1 → csr_illegal = 1, mcycle unaffected. CSRRC mscratch from 0xFF with wdata 0x0F → rdata 0xFF, mscratch then 0xF0.
